// File: rtl/clock_mgr_pkg.sv
// clock_mgr_pkg
// Shared types, status codes, DRP register masks and divide helpers for the
// MMCM CLKOUT0 reprogramming sequencer.
//   seq_state_e  : top-level sequencer states
//   rmw_state_e  : single read-modify-write engine states
//   reg1_bits()  : ClkReg1 high/low-time field for a divide value
//   reg2_bits()  : ClkReg2 edge/no_count field for a divide value
//   div_valid()  : divide value lies in DIV_MIN..DIV_MAX
package clock_mgr_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRst,
        StRmw1,
        StRmw2,
        StRel,
        StLock,
        StDone
    } seq_state_e;

    typedef enum logic [2:0] {
        RmwIdle,
        RmwRd,
        RmwWaitRd,
        RmwWr,
        RmwWaitWr
    } rmw_state_e;

    localparam logic [1:0] ST_OK     = 2'd0;
    localparam logic [1:0] ST_BADDIV = 2'd1;
    localparam logic [1:0] ST_DRPTO  = 2'd2;
    localparam logic [1:0] ST_LOCKTO = 2'd3;

    // Bits of the DRP registers that must survive the rewrite.
    localparam logic [15:0] REG1_KEEP = 16'hF000;
    localparam logic [15:0] REG2_KEEP = 16'hFF3F;

    localparam logic [7:0] DIV_MIN = 8'd1;
    localparam logic [7:0] DIV_MAX = 8'd126;

    function automatic logic div_valid(input logic [7:0] d);
        return (d >= DIV_MIN) && (d <= DIV_MAX);
    endfunction

    // {high[5:0], low[5:0]}; only called with d in 1..126, so high and low fit
    // in six bits and the 6-bit subtraction is exact.
    function automatic logic [15:0] reg1_bits(input logic [7:0] d);
        logic [5:0] high;
        logic [5:0] low;
        high = d[6:1];
        low  = d[5:0] - d[6:1];
        if (d == 8'd1) begin
            high = 6'd1;
            low  = 6'd1;
        end
        return {4'b0000, high, low};
    endfunction

    // edge lands on bit 7, no_count on bit 6.
    function automatic logic [15:0] reg2_bits(input logic [7:0] d);
        return {8'h00, d[0], (d == 8'd1), 6'b00_0000};
    endfunction

endpackage

// File: rtl/clock_mgr_drp_rmw.sv
// clock_mgr_drp_rmw
// One DRP read-modify-write: read addr, keep the keep_mask bits of the read
// data, OR in set_bits, write it back. Each wait for drp_drdy is bounded by
// DRP_TIMEOUT cycles.
// Ports:
//   clk, resetn           : clock, asynchronous active-low reset
//   start                 : begin an access; addr/keep_mask/set_bits sampled
//   addr, keep_mask,
//   set_bits              : access target and modify pattern
//   drp_daddr, drp_den,
//   drp_dwe, drp_di       : DRP request side
//   drp_do, drp_drdy      : DRP response side
//   done                  : write acknowledged (combinational, one cycle)
//   timeout               : a wait expired (combinational, one cycle)
module clock_mgr_drp_rmw
    import clock_mgr_pkg::*;
#(
    parameter int unsigned DRP_TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [6:0]  addr,
    input  logic [15:0] keep_mask,
    input  logic [15:0] set_bits,
    output logic [6:0]  drp_daddr,
    output logic        drp_den,
    output logic        drp_dwe,
    output logic [15:0] drp_di,
    input  logic [15:0] drp_do,
    input  logic        drp_drdy,
    output logic        done,
    output logic        timeout
);

    localparam int unsigned CW = (DRP_TIMEOUT > 1) ? $clog2(DRP_TIMEOUT) : 1;

    rmw_state_e     state_q, state_d;
    logic [6:0]     addr_q, addr_d;
    logic [15:0]    keep_q, keep_d;
    logic [15:0]    set_q, set_d;
    logic [15:0]    di_q, di_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           cnt_expired;

    assign cnt_expired = (cnt_q == CW'(DRP_TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        keep_d  = keep_q;
        set_d   = set_q;
        di_d    = di_q;
        cnt_d   = cnt_q;
        done    = 1'b0;
        timeout = 1'b0;

        unique case (state_q)
            RmwIdle: begin
                if (start) begin
                    addr_d  = addr;
                    keep_d  = keep_mask;
                    set_d   = set_bits;
                    state_d = RmwRd;
                end
            end
            RmwRd: begin
                cnt_d   = '0;
                state_d = RmwWaitRd;
            end
            RmwWaitRd: begin
                if (drp_drdy) begin
                    di_d    = (drp_do & keep_q) | set_q;
                    state_d = RmwWr;
                end else if (cnt_expired) begin
                    timeout = 1'b1;
                    state_d = RmwIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RmwWr: begin
                cnt_d   = '0;
                state_d = RmwWaitWr;
            end
            RmwWaitWr: begin
                if (drp_drdy) begin
                    done = 1'b1;
                    // Back-to-back accesses: the caller may start the next one
                    // in the same cycle this one completes.
                    if (start) begin
                        addr_d  = addr;
                        keep_d  = keep_mask;
                        set_d   = set_bits;
                        state_d = RmwRd;
                    end else begin
                        state_d = RmwIdle;
                    end
                end else if (cnt_expired) begin
                    timeout = 1'b1;
                    state_d = RmwIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = RmwIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= RmwIdle;
            addr_q  <= '0;
            keep_q  <= '0;
            set_q   <= '0;
            di_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            keep_q  <= keep_d;
            set_q   <= set_d;
            di_q    <= di_d;
            cnt_q   <= cnt_d;
        end
    end

    // Strobes decode straight from state so an asynchronous reset drops them.
    assign drp_den   = (state_q == RmwRd) || (state_q == RmwWr);
    assign drp_dwe   = (state_q == RmwWr);
    assign drp_daddr = addr_q;
    assign drp_di    = di_q;

endmodule

// File: rtl/clock_mgr_drp_seq.sv
// clock_mgr_drp_seq
// Reprograms the MMCM CLKOUT0 divider at run time: holds the MMCM in reset,
// rewrites ClkReg1 and ClkReg2 over DRP, releases reset, waits for LOCKED and
// reports a status code.
// Ports:
//   clk, resetn          : clock, asynchronous active-low reset
//   cfg_div, cfg_start   : requested divide and its one-cycle strobe
//   busy, done, status   : request in flight, completion pulse, result code
//   cur_div              : last divide that locked successfully
//   mmcm_rst, mmcm_locked: MMCM reset (active high) and lock indication
//   drp_*                : MMCM dynamic reconfiguration port
module clock_mgr_drp_seq
    import clock_mgr_pkg::*;
#(
    parameter logic [6:0]  REG1_ADDR    = 7'h08,
    parameter logic [6:0]  REG2_ADDR    = 7'h09,
    parameter int unsigned DRP_TIMEOUT  = 256,
    parameter int unsigned LOCK_TIMEOUT = 100000,
    parameter int unsigned LOCK_BLANK   = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  cfg_div,
    input  logic        cfg_start,
    output logic        busy,
    output logic        done,
    output logic [1:0]  status,
    output logic [7:0]  cur_div,
    output logic        mmcm_rst,
    input  logic        mmcm_locked,
    output logic [6:0]  drp_daddr,
    output logic        drp_den,
    output logic        drp_dwe,
    output logic [15:0] drp_di,
    input  logic [15:0] drp_do,
    input  logic        drp_drdy
);

    localparam int unsigned LOCK_CW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

    seq_state_e         state_q, state_d;
    logic [7:0]         div_q, div_d;
    logic [1:0]         status_q, status_d;
    logic [7:0]         cur_div_q, cur_div_d;
    logic [LOCK_CW-1:0] lock_cnt_q, lock_cnt_d;

    logic        rmw_start;
    logic [6:0]  rmw_addr;
    logic [15:0] rmw_keep;
    logic [15:0] rmw_set;
    logic        rmw_done;
    logic        rmw_timeout;

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        status_d   = status_q;
        cur_div_d  = cur_div_q;
        lock_cnt_d = lock_cnt_q;
        rmw_start  = 1'b0;
        rmw_addr   = REG1_ADDR;
        rmw_keep   = REG1_KEEP;
        rmw_set    = reg1_bits(div_q);

        unique case (state_q)
            StIdle: begin
                if (cfg_start) begin
                    div_d = cfg_div;
                    if (div_valid(cfg_div)) begin
                        state_d = StRst;
                    end else begin
                        status_d = ST_BADDIV;
                        state_d  = StDone;
                    end
                end
            end
            StRst: begin
                rmw_start = 1'b1;
                state_d   = StRmw1;
            end
            StRmw1: begin
                // Present the ClkReg2 access so it launches the cycle the
                // ClkReg1 write completes.
                rmw_addr = REG2_ADDR;
                rmw_keep = REG2_KEEP;
                rmw_set  = reg2_bits(div_q);
                if (rmw_timeout) begin
                    status_d = ST_DRPTO;
                    state_d  = StDone;
                end else if (rmw_done) begin
                    rmw_start = 1'b1;
                    state_d   = StRmw2;
                end
            end
            StRmw2: begin
                if (rmw_timeout) begin
                    status_d = ST_DRPTO;
                    state_d  = StDone;
                end else if (rmw_done) begin
                    state_d = StRel;
                end
            end
            StRel: begin
                lock_cnt_d = '0;
                state_d    = StLock;
            end
            StLock: begin
                // lock_cnt_q is the index of this cycle within LOCK.
                if ((lock_cnt_q >= LOCK_CW'(LOCK_BLANK)) && mmcm_locked) begin
                    status_d  = ST_OK;
                    cur_div_d = div_q;
                    state_d   = StDone;
                end else if (lock_cnt_q == LOCK_CW'(LOCK_TIMEOUT - 1)) begin
                    status_d = ST_LOCKTO;
                    state_d  = StDone;
                end else begin
                    lock_cnt_d = lock_cnt_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StIdle;
            div_q      <= '0;
            status_q   <= ST_OK;
            cur_div_q  <= '0;
            lock_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            status_q   <= status_d;
            cur_div_q  <= cur_div_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    // Decoded from state so an asynchronous reset releases them immediately.
    always_comb begin
        busy     = (state_q != StIdle);
        done     = (state_q == StDone);
        mmcm_rst = (state_q == StRst) || (state_q == StRmw1) || (state_q == StRmw2);
    end

    assign status  = status_q;
    assign cur_div = cur_div_q;

    clock_mgr_drp_rmw #(
        .DRP_TIMEOUT (DRP_TIMEOUT)
    ) u_rmw (
        .clk       (clk),
        .resetn    (resetn),
        .start     (rmw_start),
        .addr      (rmw_addr),
        .keep_mask (rmw_keep),
        .set_bits  (rmw_set),
        .drp_daddr (drp_daddr),
        .drp_den   (drp_den),
        .drp_dwe   (drp_dwe),
        .drp_di    (drp_di),
        .drp_do    (drp_do),
        .drp_drdy  (drp_drdy),
        .done      (rmw_done),
        .timeout   (rmw_timeout)
    );

endmodule
